// File: rtl/ospfb_frame_sink_pkg.sv
// Shared defaults and state encodings for the OSPFB frame sink.
package ospfb_pkg;
   localparam int WIDTH_DEF     = 16;
   localparam int FFT_LEN_DEF   = 32;
   localparam int TUSER_WID_DEF = 8;

   typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_state_t;
   typedef enum logic {FILL = 1'b0, SYNC = 1'b1} wr_state_t;
endpackage

// File: rtl/ospfb_frame_sink_if.sv
// AXI-Stream style bin stream from the FFT into the frame sink.
interface ospfb_frame_sink_if
   import ospfb_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int TUSER_WID = TUSER_WID_DEF
) ();
   logic [2*WIDTH-1:0]   tdata;
   logic                 tvalid;
   logic                 tready;
   logic                 tlast;
   logic [TUSER_WID-1:0] tuser;

   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ospfb_frame_sink_ram.sv
// Simple dual-port RAM holding both frame banks; address MSB selects the bank.
module frame_bank_ram #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is reset; array contents survive rst.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/ospfb_frame_sink.sv
// Ping-pong frame sink for OSPFB FFT bins with framing checks.
// Define OSPFB_FRAME_SINK_TUSER_CHECK_EN to check tuser bin index against position.
module ospfb_frame_sink
   import ospfb_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int FFT_LEN   = FFT_LEN_DEF,
   parameter int TUSER_WID = TUSER_WID_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   ospfb_frame_sink_if.slave          s_axis,
   output logic                       frame_ready,
   input  logic                       rd_en,
   input  logic [$clog2(FFT_LEN)-1:0] rd_addr,
   output logic [2*WIDTH-1:0]         rd_data,
   output logic                       rd_valid,
   input  logic                       frame_ack,
   output logic [31:0]                frame_cnt,
   output logic                       err_tuser,
   output logic                       err_tlast_unexpected,
   output logic                       err_tlast_missing,
   output logic                       err_drop
);
   localparam int              IDXW     = $clog2(FFT_LEN);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FFT_LEN - 1);

   wr_state_t       state, state_nxt;
   logic [IDXW-1:0] idx, idx_nxt;
   bank_state_t     bank_state [2];
   logic            wr_bank, rd_bank;
   logic            beat, wr_en, frame_done, ack_ok, tuser_bad;
   logic            e_tuser, e_unexp, e_missing, e_drop;
   logic            unused_tuser;

   assign s_axis.tready = ~rst;
   assign beat          = s_axis.tvalid & s_axis.tready;
   // Completions and acks both alternate banks, so rd_bank is always the oldest FULL one.
   assign frame_ready   = (bank_state[rd_bank] == FULL);
   assign ack_ok        = frame_ack & frame_ready;
   assign unused_tuser  = ^s_axis.tuser;

`ifdef OSPFB_FRAME_SINK_TUSER_CHECK_EN
   assign tuser_bad = (s_axis.tuser[IDXW-1:0] != idx);
`else
   assign tuser_bad = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      wr_en      = 1'b0;
      frame_done = 1'b0;
      e_tuser    = 1'b0;
      e_unexp    = 1'b0;
      e_missing  = 1'b0;
      e_drop     = 1'b0;
      if (beat) begin
         if (state == FILL) begin
            if (idx == '0 && bank_state[wr_bank] == FULL) begin
               e_drop    = 1'b1;
               state_nxt = SYNC;
            end else if (tuser_bad) begin
               e_tuser   = 1'b1;
               idx_nxt   = '0;
               state_nxt = SYNC;
            end else if (s_axis.tlast && idx != IDX_LAST) begin
               e_unexp = 1'b1;
               idx_nxt = '0;
            end else if (!s_axis.tlast && idx == IDX_LAST) begin
               e_missing = 1'b1;
               idx_nxt   = '0;
               state_nxt = SYNC;
            end else begin
               wr_en = 1'b1;
               if (idx == IDX_LAST) begin
                  frame_done = 1'b1;
                  idx_nxt    = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end else if (s_axis.tlast) begin
            state_nxt = FILL;
            idx_nxt   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= FILL;
         idx                  <= '0;
         bank_state[0]        <= FREE;
         bank_state[1]        <= FREE;
         wr_bank              <= 1'b0;
         rd_bank              <= 1'b0;
         frame_cnt            <= '0;
         rd_valid             <= 1'b0;
         err_tuser            <= 1'b0;
         err_tlast_unexpected <= 1'b0;
         err_tlast_missing    <= 1'b0;
         err_drop             <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         // wr_bank differs from rd_bank whenever an ack is honoured, so both may land together.
         if (frame_done) begin
            bank_state[wr_bank] <= FULL;
            wr_bank             <= ~wr_bank;
            frame_cnt           <= frame_cnt + 32'd1;
         end
         if (ack_ok) begin
            bank_state[rd_bank] <= FREE;
            rd_bank             <= ~rd_bank;
         end
         rd_valid             <= rd_en & frame_ready;
         err_tuser            <= e_tuser;
         err_tlast_unexpected <= e_unexp;
         err_tlast_missing    <= e_missing;
         err_drop             <= e_drop;
      end
   end

   frame_bank_ram #(.DW(2*WIDTH), .AW(IDXW+1)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr ({wr_bank, idx}),
      .wdata (s_axis.tdata),
      .re    (rd_en & frame_ready),
      .raddr ({rd_bank, rd_addr}),
      .rdata (rd_data)
   );
endmodule
